branch_resolve: RTL and testbench

- Consumer end of the ALU branch flag interface.
- Latches the four ALU result flags (zero, non-zero, greater-than-zero, less-than-zero) into a flag register.
- Owns the 16-bit program counter.
- Resolves conditional branch requests, handed over by the decoder through a valid/ready handshake, into a PC redirect, with optional link-register write.
- Sits between the ALU flag generator, the instruction decoder and the register file in the unpipelined core.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_cond_eval.sv | 27 ++
 rtl/branch_resolve.sv | 148 ++++++++++++++
 tb/tb_branch_resolve.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition codes,
// FSM encoding and flag register layout.
package branch_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_GT     = 3'b011;
  localparam logic [2:0] COND_LT     = 3'b100;
  localparam logic [2:0] COND_GE     = 3'b101;
  localparam logic [2:0] COND_LE     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  localparam int FLAG_ZF   = 3;
  localparam int FLAG_NEZF = 2;
  localparam int FLAG_GZF  = 1;
  localparam int FLAG_LZF  = 0;

  localparam logic [3:0] FLAG_RST = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_LINK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: maps a condition code and the
// flag vector {zf,nezf,gzf,lzf} to a take decision.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  // decode condition against the snapshot flags
  always_comb begin
    take = 1'b0;
    unique case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_EQ:     take = flags[FLAG_ZF];
      COND_NE:     take = flags[FLAG_NEZF];
      COND_GT:     take = flags[FLAG_GZF];
      COND_LT:     take = flags[FLAG_LZF];
      COND_GE:     take = flags[FLAG_GZF] | flags[FLAG_ZF];
      COND_LE:     take = flags[FLAG_LZF] | flags[FLAG_ZF];
      COND_NEVER:  take = 1'b0;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve unit: flag register, program counter and branch FSM.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zf,
  input  logic            nezf,
  input  logic            gzf,
  input  logic            lzf,
  input  logic            flag_we,
  input  logic            pc_advance,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic            br_abs,
  input  logic            br_link,
  input  logic [PC_W-1:0] br_imm,
  input  logic [PC_W-1:0] br_reg,
  output logic [PC_W-1:0] pc,
  output logic            redirect,
  output logic            taken,
  output logic            link_we,
  output logic [PC_W-1:0] link_data,
`ifdef BRANCH_STATS_EN
  output logic [15:0]     stat_total,
  output logic [15:0]     stat_taken,
`endif
  output logic [3:0]      flags_q
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [2:0]      s_cond;
  logic            s_abs;
  logic            s_link;
  logic [PC_W-1:0] s_imm;
  logic [PC_W-1:0] s_reg;
  logic [PC_W-1:0] pc_cap;
  logic [3:0]      s_flags;

  logic [3:0]      flags_in;
  logic            take;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] next_pc;

  assign flags_in = {zf, nezf, gzf, lzf};
  assign seq_pc   = pc_cap + ONE;
  assign target   = s_abs ? s_reg : seq_pc + s_imm;
  assign next_pc  = take ? target : seq_pc;

  branch_cond_eval u_cond (
    .cond  (s_cond),
    .flags (s_flags),
    .take  (take)
  );

  // flag register, writable in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= FLAG_RST;
    else if (flag_we) flags_q <= flags_in;
  end

  // branch FSM with registered handshake, redirect and link outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      br_ready  <= 1'b1;
      redirect  <= 1'b0;
      taken     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      s_cond    <= COND_NEVER;
      s_abs     <= 1'b0;
      s_link    <= 1'b0;
      s_imm     <= '0;
      s_reg     <= '0;
      pc_cap    <= '0;
      s_flags   <= FLAG_RST;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (br_valid) begin
            s_cond   <= br_cond;
            s_abs    <= br_abs;
            s_link   <= br_link;
            s_imm    <= br_imm;
            s_reg    <= br_reg;
            pc_cap   <= pc;
            s_flags  <= flag_we ? flags_in : flags_q;
            br_ready <= 1'b0;
            state    <= ST_EVAL;
          end else if (pc_advance) begin
            pc <= pc + ONE;
          end
        end
        ST_EVAL: begin
          if (take && s_link) begin
            link_we   <= 1'b1;
            link_data <= seq_pc;
            state     <= ST_LINK;
          end else begin
            redirect <= 1'b1;
            taken    <= take;
            pc       <= next_pc;
            state    <= ST_DONE;
          end
        end
        ST_LINK: begin
          link_we  <= 1'b0;
          redirect <= 1'b1;
          taken    <= take;
          pc       <= next_pc;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          redirect <= 1'b0;
          taken    <= 1'b0;
          br_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // saturating counters of resolved and taken branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (redirect) begin
      if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
      if (taken && stat_taken != 16'hFFFF)
        stat_taken <= stat_taken + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
// Checks are sampled 1 time unit after each rising clock edge.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        zf, nezf, gzf, lzf;
  logic        flag_we, pc_advance;
  logic        br_valid, br_ready;
  logic [2:0]  br_cond;
  logic        br_abs, br_link;
  logic [15:0] br_imm, br_reg;
  logic [15:0] pc;
  logic        redirect, taken, link_we;
  logic [15:0] link_data;
  logic [3:0]  flags_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_total, stat_taken;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .zf         (zf),
    .nezf       (nezf),
    .gzf        (gzf),
    .lzf        (lzf),
    .flag_we    (flag_we),
    .pc_advance (pc_advance),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_abs     (br_abs),
    .br_link    (br_link),
    .br_imm     (br_imm),
    .br_reg     (br_reg),
    .pc         (pc),
    .redirect   (redirect),
    .taken      (taken),
    .link_we    (link_we),
    .link_data  (link_data),
`ifdef BRANCH_STATS_EN
    .stat_total (stat_total),
    .stat_taken (stat_taken),
`endif
    .flags_q    (flags_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {zf, nezf, gzf, lzf} = f;
  endtask

  task automatic write_flags(input logic [3:0] f);
    set_flags(f);
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic a,
                       input logic l, input logic [15:0] imm,
                       input logic [15:0] r);
    br_cond  = c;
    br_abs   = a;
    br_link  = l;
    br_imm   = imm;
    br_reg   = r;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic advance(input int n);
    pc_advance = 1'b1;
    repeat (n) tick();
    pc_advance = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {zf, nezf, gzf, lzf} = 4'b0000;
    flag_we = 0; pc_advance = 0; br_valid = 0;
    br_cond = 0; br_abs = 0; br_link = 0;
    br_imm = 0; br_reg = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_flags", flags_q, 4'b1000);
    chk("rst_ready", br_ready, 1'b1);
    chk("rst_redir", redirect, 1'b0);
    chk("rst_taken", taken, 1'b0);
    chk("rst_lwe", link_we, 1'b0);
    chk("rst_ldata", link_data, 16'h0000);

    pc_advance = 1'b1;
    tick(); chk("adv_pc1", pc, 16'h0001);
    tick(); chk("adv_pc2", pc, 16'h0002);
    tick(); chk("adv_pc3", pc, 16'h0003);
    pc_advance = 1'b0;
    advance(13);
    chk("adv_pc10", pc, 16'h0010);

    // EQ relative taken
    write_flags(4'b1000);
    chk("flags_1000", flags_q, 4'b1000);
    issue(3'b001, 0, 0, 16'h0005, 16'h0000);
    chk("eq_ready_n1", br_ready, 1'b0);
    chk("eq_redir_n1", redirect, 1'b0);
    tick();
    chk("eq_redir_n2", redirect, 1'b1);
    chk("eq_taken", taken, 1'b1);
    chk("eq_pc", pc, 16'h0016);
    tick();
    chk("eq_redir_off", redirect, 1'b0);
    chk("eq_ready_back", br_ready, 1'b1);

    // LT not taken, GE taken on positive flags
    advance(10);
    chk("pc_20", pc, 16'h0020);
    write_flags(4'b0110);
    chk("flags_0110", flags_q, 4'b0110);
    issue(3'b100, 0, 0, 16'h0010, 16'h0000);
    tick();
    chk("lt_redir", redirect, 1'b1);
    chk("lt_taken", taken, 1'b0);
    chk("lt_pc", pc, 16'h0021);
    tick();
    issue(3'b101, 0, 0, 16'h0010, 16'h0000);
    tick();
    chk("ge_redir", redirect, 1'b1);
    chk("ge_taken", taken, 1'b1);
    chk("ge_pc", pc, 16'h0032);
    tick();

    // write-first snapshot, later flag write ignored
    write_flags(4'b0101);
    chk("flags_0101", flags_q, 4'b0101);
    set_flags(4'b1000);
    flag_we = 1'b1;
    issue(3'b001, 0, 0, 16'h0002, 16'h0000);
    set_flags(4'b0101);
    tick();
    flag_we = 1'b0;
    chk("wf_redir", redirect, 1'b1);
    chk("wf_taken", taken, 1'b1);
    chk("wf_pc", pc, 16'h0035);
    chk("wf_flags", flags_q, 4'b0101);
    tick();

    // absolute branch with link
    advance(11);
    chk("pc_40", pc, 16'h0040);
    issue(3'b000, 1, 1, 16'h0000, 16'h1234);
    chk("lk_lwe_n1", link_we, 1'b0);
    tick();
    chk("lk_lwe_n2", link_we, 1'b1);
    chk("lk_ldata", link_data, 16'h0041);
    chk("lk_redir_n2", redirect, 1'b0);
    tick();
    chk("lk_redir_n3", redirect, 1'b1);
    chk("lk_taken", taken, 1'b1);
    chk("lk_lwe_n3", link_we, 1'b0);
    chk("lk_pc", pc, 16'h1234);
    tick();

    // wrap: jump to FFFF then relative +0
    issue(3'b000, 1, 0, 16'h0000, 16'hFFFF);
    tick();
    chk("ffff_pc", pc, 16'hFFFF);
    tick();
    issue(3'b000, 0, 0, 16'h0000, 16'h0000);
    tick();
    chk("wrap_taken", taken, 1'b1);
    chk("wrap_pc", pc, 16'h0000);
    tick();

    // never with link; pc_advance held high throughout
    pc_advance = 1'b1;
    issue(3'b111, 0, 1, 16'h0100, 16'h0000);
    chk("nv_pc_hold", pc, 16'h0000);
    tick();
    chk("nv_lwe", link_we, 1'b0);
    chk("nv_redir", redirect, 1'b1);
    chk("nv_taken", taken, 1'b0);
    chk("nv_pc", pc, 16'h0001);
    pc_advance = 1'b0;
    tick();

    // not-taken with link: no link write
    write_flags(4'b0110);
    issue(3'b001, 0, 1, 16'h0100, 16'h0000);
    tick();
    chk("ntl_lwe", link_we, 1'b0);
    chk("ntl_redir", redirect, 1'b1);
    chk("ntl_pc", pc, 16'h0002);
    tick();

    // reset during LINK
    issue(3'b000, 1, 1, 16'h0000, 16'h5555);
    tick();
    chk("rl_lwe", link_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("rl_pc", pc, 16'h0000);
    chk("rl_lwe_off", link_we, 1'b0);
    chk("rl_ready", br_ready, 1'b1);
    chk("rl_flags", flags_q, 4'b1000);
    tick();
    rst = 1'b0;
    tick();
    chk("rl_redir", redirect, 1'b0);
    chk("rl_pc2", pc, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
